decision_unit: RTL and testbench
================================

# decision_unit

Responder for the decision handshake issued by the SAT engine core controller. On a one-cycle start pulse it scans the local bin's variable-state vector for the first unassigned variable, assigns it a decision value, advances the decision level, and returns a one-cycle done pulse. It also reports when no free variable remains, and accepts a level reload from the backtrack path. Sits inside the sat_engine next to the implication and conflict-analysis units.

## Interface
- NUM_VARS, 8, variables held in the local bin
- WIDTH_VAR_IDX, 3, width of a variable index (≥ clog2(NUM_VARS))
- WIDTH_LVL, 16, decision level width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start_decision_i  in  1  one-cycle request pulse from the controller
- var_state_i  in  2*NUM_VARS  per-variable state; var k at bits [2k+1:2k]
- load_lvl_i  in  1  load cur_lvl_o from bkt_lvl_i (backtrack)
- bkt_lvl_i  in  WIDTH_LVL  level to load
- assign_en_o  out  1  one-cycle strobe: write decision into the variable array
- decided_var_o  out  WIDTH_VAR_IDX  index of decided variable
- decided_value_o  out  2  value written (always VAR_FALSE = 2'b01)
- cur_lvl_o  out  WIDTH_LVL  current decision level
- no_free_var_o  out  1  last decision found no free variable
- done_decision_o  out  1  one-cycle completion pulse
- busy_o  out  1  high in any state except IDLE

## Operation
- Var encoding: 2'b00 free, 2'b01 false, 2'b10 true, 2'b11 illegal, treated as assigned (not free).
- States: IDLE, SCAN, ASSIGN, DONE. Outputs Moore-decoded from the registered state plus registered datapath.
- IDLE: on start_decision_i → SCAN, scan_idx ← 0, no_free_var_o ← 0.
- SCAN, one variable per cycle: if var[scan_idx] free → ASSIGN, decided_var_o ← scan_idx; else if scan_idx == NUM_VARS-1 → DONE, no_free_var_o ← 1; else scan_idx + 1.
- var_state_i is sampled live each SCAN cycle. The environment holds it stable while busy_o is high.
- ASSIGN (1 cycle): assign_en_o = 1, decided_value_o = 2'b01. At exit, cur_lvl_o + 1, saturating at 2^WIDTH_LVL-1 (no wrap). → DONE.
- DONE (1 cycle): done_decision_o = 1 → IDLE.
- start_decision_i while busy_o is high is ignored (not queued).
- load_lvl_i has priority in every state: cur_lvl_o ← bkt_lvl_i, state → IDLE, scan_idx ← 0. An in-flight decision is aborted with no assign_en_o and no done_decision_o. When asserted with start_decision_i in IDLE, load wins and the start is dropped.
- decided_var_o and no_free_var_o hold their values until the next accepted start or reset.

## Timing
- Cycle 1 is the first cycle after the edge that samples start_decision_i = 1.
- Free var at index k: SCAN during cycles 1..k+1, assign_en_o in cycle k+2, done_decision_o in cycle k+3. cur_lvl_o already shows the incremented value in cycle k+3.
- No free var: SCAN during cycles 1..NUM_VARS, done_decision_o with no_free_var_o = 1 in cycle NUM_VARS+1. Level is unchanged.
- busy_o is high in cycles 1 through the done cycle inclusive. A new start is accepted in the cycle after done.
- load_lvl_i takes effect at the next edge; cur_lvl_o shows bkt_lvl_i one cycle later.
- Reset (async, any time): state IDLE, scan_idx 0, cur_lvl_o 0, decided_var_o 0, decided_value_o 0. assign_en_o, done_decision_o, no_free_var_o and busy_o are all 0. An in-flight operation is dropped silently.

## Structure
- Shared sat-engine package: var encodings (VAR_FREE, VAR_FALSE, VAR_TRUE), decision-unit state encoding, default WIDTH_LVL.
- One FSM plus scan counter and level register in a single module. No sub-module is required. The saturating level register may be factored out as lvl_counter if it is reused by the backtrack unit.

## Test plan
- NUM_VARS=8, state vector = all free except var0=01 and var1=10; pulse start → assign_en_o in cycle 4 with decided_var_o=2, decided_value_o=01; done in cycle 5; cur_lvl_o 0→1.
- All vars assigned (incl. one 2'b11) → no assign_en_o; done in cycle 9 with no_free_var_o=1; cur_lvl_o unchanged.
- load_lvl_i=1 with bkt_lvl_i=5 during SCAN → no done and no assign; cur_lvl_o=5; busy_o=0 next cycle; a fresh start then yields lvl 6.
- cur_lvl_o loaded to 16'hFFFF, decision on a free var → cur_lvl_o stays 16'hFFFF, done still pulses.
- Second start pulse in cycle 2 of a running decision → ignored: exactly one assign_en_o and one done_decision_o.
- rst asserted mid-SCAN (asynchronous, between edges) → all outputs 0 immediately; after release, start on var7-only-free → done in cycle 10, decided_var_o=7.

Source files
------------

// File: rtl/decision_unit_pkg.sv
// Shared sat-engine definitions: variable-state encodings, decision-unit FSM states,
// and the default decision-level width.
package decision_unit_pkg;

    localparam logic [1:0] VAR_FREE    = 2'b00;
    localparam logic [1:0] VAR_FALSE   = 2'b01;
    localparam logic [1:0] VAR_TRUE    = 2'b10;
    localparam logic [1:0] VAR_ILLEGAL = 2'b11;

    localparam int unsigned DefaultWidthLvl = 16;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StAssign,
        StDone
    } du_state_e;

    // Only the all-zero encoding counts as free; 2'b11 is treated as assigned.
    function automatic logic var_is_free(logic [1:0] state);
        return state == VAR_FREE;
    endfunction

endpackage

// File: rtl/decision_unit_if.sv
// Decision handshake between the core controller (master) and the decision unit (slave).
interface decision_unit_if
    import decision_unit_pkg::*;
#(
    parameter int unsigned NUM_VARS      = 8,
    parameter int unsigned WIDTH_VAR_IDX = 3,
    parameter int unsigned WIDTH_LVL     = DefaultWidthLvl
);

    logic                      start_decision_i;
    logic [2*NUM_VARS-1:0]     var_state_i;
    logic                      load_lvl_i;
    logic [WIDTH_LVL-1:0]      bkt_lvl_i;
    logic                      assign_en_o;
    logic [WIDTH_VAR_IDX-1:0]  decided_var_o;
    logic [1:0]                decided_value_o;
    logic [WIDTH_LVL-1:0]      cur_lvl_o;
    logic                      no_free_var_o;
    logic                      done_decision_o;
    logic                      busy_o;

    modport master (
        output start_decision_i,
        output var_state_i,
        output load_lvl_i,
        output bkt_lvl_i,
        input  assign_en_o,
        input  decided_var_o,
        input  decided_value_o,
        input  cur_lvl_o,
        input  no_free_var_o,
        input  done_decision_o,
        input  busy_o
    );

    modport slave (
        input  start_decision_i,
        input  var_state_i,
        input  load_lvl_i,
        input  bkt_lvl_i,
        output assign_en_o,
        output decided_var_o,
        output decided_value_o,
        output cur_lvl_o,
        output no_free_var_o,
        output done_decision_o,
        output busy_o
    );

endinterface

// File: rtl/decision_unit.sv
// Decision responder: scans for the first free variable one per cycle, assigns it
// VAR_FALSE, bumps the saturating decision level and pulses done.
module decision_unit
    import decision_unit_pkg::*;
#(
    parameter int unsigned NUM_VARS      = 8,
    parameter int unsigned WIDTH_VAR_IDX = 3,
    parameter int unsigned WIDTH_LVL     = DefaultWidthLvl
) (
    input logic             clk,
    input logic             rst,
    decision_unit_if.slave  bus
);

    localparam logic [WIDTH_VAR_IDX-1:0] LastIdx = WIDTH_VAR_IDX'(NUM_VARS - 1);
    localparam logic [WIDTH_LVL-1:0]     LvlMax  = '1;

    du_state_e                state_q, state_d;
    logic [WIDTH_VAR_IDX-1:0] scan_idx_q, scan_idx_d;
    logic [WIDTH_VAR_IDX-1:0] decided_var_q, decided_var_d;
    logic                     no_free_q, no_free_d;
    logic [WIDTH_LVL-1:0]     lvl_q, lvl_d;
    logic [1:0]               cur_var;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            scan_idx_q    <= '0;
            decided_var_q <= '0;
            no_free_q     <= 1'b0;
            lvl_q         <= '0;
        end else begin
            state_q       <= state_d;
            scan_idx_q    <= scan_idx_d;
            decided_var_q <= decided_var_d;
            no_free_q     <= no_free_d;
            lvl_q         <= lvl_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        scan_idx_d    = scan_idx_q;
        decided_var_d = decided_var_q;
        no_free_d     = no_free_q;
        lvl_d         = lvl_q;
        // Variable k occupies bits [2k+1:2k]; sampled live every scan cycle.
        cur_var       = bus.var_state_i[{scan_idx_q, 1'b0} +: 2];

        if (bus.load_lvl_i) begin
            // Backtrack reload overrides everything, aborting any decision in flight.
            lvl_d      = bus.bkt_lvl_i;
            state_d    = StIdle;
            scan_idx_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start_decision_i) begin
                        state_d    = StScan;
                        scan_idx_d = '0;
                        no_free_d  = 1'b0;
                    end
                end
                StScan: begin
                    if (var_is_free(cur_var)) begin
                        state_d       = StAssign;
                        decided_var_d = scan_idx_q;
                    end else if (scan_idx_q == LastIdx) begin
                        state_d   = StDone;
                        no_free_d = 1'b1;
                    end else begin
                        scan_idx_d = scan_idx_q + WIDTH_VAR_IDX'(1);
                    end
                end
                StAssign: begin
                    lvl_d   = (lvl_q == LvlMax) ? lvl_q : lvl_q + WIDTH_LVL'(1);
                    state_d = StDone;
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_comb begin
        bus.assign_en_o     = (state_q == StAssign);
        bus.decided_value_o = (state_q == StAssign) ? VAR_FALSE : VAR_FREE;
        bus.done_decision_o = (state_q == StDone);
        bus.busy_o          = (state_q != StIdle);
        bus.decided_var_o   = decided_var_q;
        bus.no_free_var_o   = no_free_q;
        bus.cur_lvl_o       = lvl_q;
    end

endmodule

// File: tb/tb_decision_unit.sv
// Directed bench for decision_unit: scan latency, no-free case, backtrack load,
// level saturation, ignored restarts and asynchronous reset.
module tb_decision_unit;

    localparam int unsigned NV = 8;
    localparam int unsigned WI = 3;
    localparam int unsigned WL = 16;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   n_assign;
    int   n_done;

    decision_unit_if #(.NUM_VARS(NV), .WIDTH_VAR_IDX(WI), .WIDTH_LVL(WL)) bus ();

    decision_unit #(.NUM_VARS(NV), .WIDTH_VAR_IDX(WI), .WIDTH_LVL(WL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        n_assign = 0;
        n_done   = 0;
    end

    always @(negedge clk) begin
        if (bus.assign_en_o === 1'b1) n_assign <= n_assign + 1;
        if (bus.done_decision_o === 1'b1) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle and follow the decision to its done pulse (bounded).
    // Returns the cycle numbers of assign_en_o and done_decision_o (0 = not seen).
    task automatic decide(output int a_cyc, output int d_cyc, output logic [1:0] a_val,
                          output logic busy1);
        a_cyc = 0;
        d_cyc = 0;
        a_val = 2'bxx;
        bus.start_decision_i = 1'b1;
        step();
        bus.start_decision_i = 1'b0;
        busy1 = bus.busy_o;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (bus.assign_en_o === 1'b1 && a_cyc == 0) begin
                a_cyc = cyc;
                a_val = bus.decided_value_o;
            end
            if (bus.done_decision_o === 1'b1) begin
                d_cyc = cyc;
                break;
            end
            step();
        end
    endtask

    int         a_cyc;
    int         d_cyc;
    int         base_a;
    int         base_d;
    logic [1:0] a_val;
    logic       busy1;

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.start_decision_i = 1'b0;
        bus.var_state_i      = '0;
        bus.load_lvl_i       = 1'b0;
        bus.bkt_lvl_i        = '0;
        #12;
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_assign", 32'(bus.assign_en_o), 0);
        chk("rst_done", 32'(bus.done_decision_o), 0);
        chk("rst_nofree", 32'(bus.no_free_var_o), 0);
        chk("rst_lvl", 32'(bus.cur_lvl_o), 0);
        chk("rst_var", 32'(bus.decided_var_o), 0);
        chk("rst_val", 32'(bus.decided_value_o), 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // var0=01, var1=10, rest free -> var2 decided
        bus.var_state_i = 16'h0009;
        decide(a_cyc, d_cyc, a_val, busy1);
        chk("t1_busy_c1", 32'(busy1), 1);
        chk("t1_assign_cyc", 32'(a_cyc), 4);
        chk("t1_value", 32'(a_val), 32'h1);
        chk("t1_done_cyc", 32'(d_cyc), 5);
        chk("t1_var", 32'(bus.decided_var_o), 2);
        chk("t1_lvl", 32'(bus.cur_lvl_o), 1);
        chk("t1_nofree", 32'(bus.no_free_var_o), 0);
        step();
        chk("t1_busy_after", 32'(bus.busy_o), 0);
        chk("t1_val_idle", 32'(bus.decided_value_o), 0);

        // Every variable assigned, including an illegal 2'b11 at var7
        bus.var_state_i = 16'hD999;
        base_a = n_assign;
        decide(a_cyc, d_cyc, a_val, busy1);
        chk("t2_done_cyc", 32'(d_cyc), 9);
        chk("t2_nofree", 32'(bus.no_free_var_o), 1);
        chk("t2_lvl", 32'(bus.cur_lvl_o), 1);
        step();
        step();
        chk("t2_no_assign", 32'(n_assign - base_a), 0);
        chk("t2_nofree_hold", 32'(bus.no_free_var_o), 1);
        chk("t2_var_hold", 32'(bus.decided_var_o), 2);

        // Backtrack load during SCAN aborts the decision
        bus.var_state_i = 16'h5155;
        base_a = n_assign;
        base_d = n_done;
        bus.start_decision_i = 1'b1;
        step();
        bus.start_decision_i = 1'b0;
        step();
        bus.load_lvl_i = 1'b1;
        bus.bkt_lvl_i  = 16'd5;
        step();
        bus.load_lvl_i = 1'b0;
        chk("t3_lvl", 32'(bus.cur_lvl_o), 5);
        chk("t3_busy", 32'(bus.busy_o), 0);
        for (int i = 0; i < 10; i++) step();
        chk("t3_no_assign", 32'(n_assign - base_a), 0);
        chk("t3_no_done", 32'(n_done - base_d), 0);
        decide(a_cyc, d_cyc, a_val, busy1);
        chk("t3_assign_cyc", 32'(a_cyc), 7);
        chk("t3_done_cyc", 32'(d_cyc), 8);
        chk("t3_var", 32'(bus.decided_var_o), 5);
        chk("t3_lvl_inc", 32'(bus.cur_lvl_o), 6);
        chk("t3_nofree_clr", 32'(bus.no_free_var_o), 0);

        // Level saturates at all-ones
        step();
        bus.load_lvl_i = 1'b1;
        bus.bkt_lvl_i  = 16'hFFFF;
        step();
        bus.load_lvl_i = 1'b0;
        decide(a_cyc, d_cyc, a_val, busy1);
        chk("t4_done_cyc", 32'(d_cyc), 8);
        chk("t4_lvl_sat", 32'(bus.cur_lvl_o), 32'hFFFF);

        // Start in the cycle right after done is accepted
        step();
        decide(a_cyc, d_cyc, a_val, busy1);
        chk("t5_b2b_done", 32'(d_cyc), 8);

        // Second start while busy is ignored
        step();
        base_a = n_assign;
        base_d = n_done;
        bus.start_decision_i = 1'b1;
        step();
        bus.start_decision_i = 1'b0;
        step();
        bus.start_decision_i = 1'b1;
        step();
        bus.start_decision_i = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("t6_one_assign", 32'(n_assign - base_a), 1);
        chk("t6_one_done", 32'(n_done - base_d), 1);

        // Asynchronous reset between edges mid-SCAN
        bus.var_state_i = 16'h1555;
        bus.start_decision_i = 1'b1;
        step();
        bus.start_decision_i = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("t7_busy", 32'(bus.busy_o), 0);
        chk("t7_lvl", 32'(bus.cur_lvl_o), 0);
        chk("t7_var", 32'(bus.decided_var_o), 0);
        chk("t7_nofree", 32'(bus.no_free_var_o), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        decide(a_cyc, d_cyc, a_val, busy1);
        chk("t7_assign_cyc", 32'(a_cyc), 9);
        chk("t7_done_cyc", 32'(d_cyc), 10);
        chk("t7_var7", 32'(bus.decided_var_o), 7);
        chk("t7_lvl1", 32'(bus.cur_lvl_o), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
